// File: rtl/forwarder.sv
// Per-port frame forwarder: pops a frame from the ingress FWFT FIFO, looks up the FIB and replicates the frame to the selected egress ports.
// Latency: 2 header pops, >=1 req cycle, then 2 replay cycles; 1 word/cycle while streaming.
// Backpressure: a full selected egress or an empty ingress stalls pop and write together; half-full egresses hold the frame before replay.
module forwarder #(
   parameter int unsigned Port = 0
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [71:0] dout,
   input  logic        empty,
   output logic        rd_en,
   output logic [71:0] port0_din,
   output logic [71:0] port1_din,
   output logic [71:0] port2_din,
   output logic [71:0] port3_din,
   output logic [71:0] port4_din,
   input  logic        port0_full,
   input  logic        port1_full,
   input  logic        port2_full,
   input  logic        port3_full,
   input  logic        port4_full,
   input  logic        port0_half,
   input  logic        port1_half,
   input  logic        port2_half,
   input  logic        port3_half,
   input  logic        port4_half,
   output logic        port0_wr_en,
   output logic        port1_wr_en,
   output logic        port2_wr_en,
   output logic        port3_wr_en,
   output logic        port4_wr_en,
   output logic        req,
   output logic [47:0] src_mac,
   output logic [47:0] dest_mac,
   input  logic        ack,
   input  logic [4:0]  forward_port
);

   localparam logic [4:0] SELF_BIT = 5'b00001 << Port;

   typedef enum logic [3:0] {
      IDLE, HDR0, HDR1, LOOKUP, WAIT, SEND0, SEND1, STREAM, DROP
   } state_t;

   state_t      state, state_nxt;
   logic [71:0] word0, word1;
   logic [4:0]  mask;
   logic [4:0]  full_vec, half_vec, wr_vec;
   logic [71:0] din;
   logic        is_last, sel_full, sel_busy;

   assign full_vec = {port4_full, port3_full, port2_full, port1_full, port0_full};
   assign half_vec = {port4_half, port3_half, port2_half, port1_half, port0_half};
   assign is_last  = (dout[71:64] != 8'hFF);
   assign sel_full = |(mask & full_vec);
   assign sel_busy = |(mask & (full_vec | half_vec));

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      wr_vec    = 5'b0;
      din       = 72'b0;
      req       = 1'b0;
      case (state)
         IDLE: if (!empty) state_nxt = HDR0;
         HDR0: if (!empty) begin
            rd_en     = 1'b1;
            state_nxt = is_last ? IDLE : HDR1;
         end
         HDR1: if (!empty) begin
            rd_en     = 1'b1;
            state_nxt = is_last ? IDLE : LOOKUP;
         end
         LOOKUP: begin
            req = 1'b1;
            if (ack) state_nxt = WAIT;
         end
         WAIT: begin
            if (mask == 5'b0)   state_nxt = DROP;
            else if (!sel_busy) state_nxt = SEND0;
         end
         SEND0: begin
            din = word0;
            if (!sel_full) begin
               wr_vec    = mask;
               state_nxt = SEND1;
            end
         end
         SEND1: begin
            din = word1;
            if (!sel_full) begin
               wr_vec    = mask;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            din = dout;
            if (!empty && !sel_full) begin
               rd_en  = 1'b1;
               wr_vec = mask;
               if (is_last) state_nxt = IDLE;
            end
         end
         DROP: if (!empty) begin
            rd_en = 1'b1;
            if (is_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The header words are replayed after the lookup, so both are kept until SEND1.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state    <= IDLE;
         word0    <= 72'b0;
         word1    <= 72'b0;
         mask     <= 5'b0;
         dest_mac <= 48'b0;
         src_mac  <= 48'b0;
      end else begin
         state <= state_nxt;
         if (state == HDR0 && rd_en) word0 <= dout;
         if (state == HDR1 && rd_en) begin
            word1    <= dout;
            dest_mac <= word0[63:16];
            src_mac  <= {word0[15:0], dout[63:32]};
         end
         if (state == LOOKUP && ack) mask <= forward_port & ~SELF_BIT;
      end
   end

   assign port0_din   = din;
   assign port1_din   = din;
   assign port2_din   = din;
   assign port3_din   = din;
   assign port4_din   = din;
   assign port0_wr_en = wr_vec[0];
   assign port1_wr_en = wr_vec[1];
   assign port2_wr_en = wr_vec[2];
   assign port3_wr_en = wr_vec[3];
   assign port4_wr_en = wr_vec[4];

endmodule

// File: tb/tb_forwarder.sv
// Scoreboard bench for forwarder: ingress/FIB/egress models driven after posedge, DUT sampled on negedge.
module tb_forwarder;
   localparam int unsigned PORT = 0;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [71:0] dout;
   logic        empty, rd_en, req, ack;
   logic [4:0]  forward_port;
   logic [47:0] src_mac, dest_mac;
   logic [71:0] port0_din, port1_din, port2_din, port3_din, port4_din;
   logic        port0_full, port1_full, port2_full, port3_full, port4_full;
   logic        port0_half, port1_half, port2_half, port3_half, port4_half;
   logic        port0_wr_en, port1_wr_en, port2_wr_en, port3_wr_en, port4_wr_en;
   logic [4:0]  full_drv, half_drv, wr_v, full_v;
   logic [71:0] din_a [5];

   always #4 sys_clk = ~sys_clk;

   forwarder #(.Port(PORT)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .dout(dout), .empty(empty), .rd_en(rd_en),
      .port0_din(port0_din), .port1_din(port1_din), .port2_din(port2_din),
      .port3_din(port3_din), .port4_din(port4_din),
      .port0_full(port0_full), .port1_full(port1_full), .port2_full(port2_full),
      .port3_full(port3_full), .port4_full(port4_full),
      .port0_half(port0_half), .port1_half(port1_half), .port2_half(port2_half),
      .port3_half(port3_half), .port4_half(port4_half),
      .port0_wr_en(port0_wr_en), .port1_wr_en(port1_wr_en), .port2_wr_en(port2_wr_en),
      .port3_wr_en(port3_wr_en), .port4_wr_en(port4_wr_en),
      .req(req), .src_mac(src_mac), .dest_mac(dest_mac), .ack(ack), .forward_port(forward_port)
   );

   assign {port4_full, port3_full, port2_full, port1_full, port0_full} = full_drv;
   assign {port4_half, port3_half, port2_half, port1_half, port0_half} = half_drv;
   assign wr_v   = {port4_wr_en, port3_wr_en, port2_wr_en, port1_wr_en, port0_wr_en};
   assign full_v = full_drv;
   assign din_a[0] = port0_din;
   assign din_a[1] = port1_din;
   assign din_a[2] = port2_din;
   assign din_a[3] = port3_din;
   assign din_a[4] = port4_din;

   typedef struct {
      logic [4:0]  fp;
      int          dly;
      logic [47:0] dmac;
      logic [47:0] smac;
   } lk_t;

   logic [71:0] in_q[$];
   logic [71:0] exp_q[5][$];
   logic [71:0] frm[$];
   lk_t         lk_q[$];
   int          checks = 0, failures = 0;
   int          wr_cnt[5];
   int          lk_done = 0, lk_cnt = 0, full3_seen = 0;
   bit          pop_pend = 0, req_s = 0, ack_take = 0;
   bit          bp_rand = 0, gap_rand = 0, force_half2 = 0, force_full3 = 0, chk_full3 = 0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: a frame whose first two words are full body words gets one lookup and is
   // copied verbatim to every port of (forward_port minus this port); anything else is a runt.
   task automatic push_frame(input logic [4:0] fp, input int dly);
      lk_t        e;
      logic [4:0] m;
      foreach (frm[i]) in_q.push_back(frm[i]);
      if (frm.size() >= 2 && frm[0][71:64] == 8'hFF && frm[1][71:64] == 8'hFF) begin
         e.fp   = fp;
         e.dly  = dly;
         e.dmac = frm[0][63:16];
         e.smac = {frm[0][15:0], frm[1][63:32]};
         lk_q.push_back(e);
         m = fp & ~(5'b00001 << PORT);
         for (int p = 0; p < 5; p++)
            if (m[p]) foreach (frm[i]) exp_q[p].push_back(frm[i]);
      end
   endtask

   task automatic build_frame(input int nbody, input int k);
      logic [7:0] lm;
      lm = ~(8'hFF >> k);
      frm.delete();
      for (int i = 0; i < nbody; i++) frm.push_back({8'hFF, $urandom, $urandom});
      frm.push_back({lm, $urandom, $urandom});
   endtask

   function automatic int pending();
      int n;
      n = in_q.size() + lk_q.size();
      for (int p = 0; p < 5; p++) n += exp_q[p].size();
      return n;
   endfunction

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (pending() > 0 && n < budget) begin
         @(posedge sys_clk);
         n++;
      end
      repeat (4) @(posedge sys_clk);
      chk(name, 96'(pending()), 96'd0);
   endtask

   // Monitor: pops expectations whenever the DUT writes or requests.
   initial begin
      for (int p = 0; p < 5; p++) wr_cnt[p] = 0;
      forever begin
         @(negedge sys_clk);
         if (sys_rst) begin
            pop_pend = 0;
            req_s    = 0;
            ack_take = 0;
         end else begin
            pop_pend = rd_en;
            req_s    = req;
            ack_take = req && ack;
            for (int p = 0; p < 5; p++) begin
               if (full_v[p]) chk($sformatf("write_into_full_p%0d", p), 96'(wr_v[p]), 96'd0);
               if (wr_v[p]) begin
                  wr_cnt[p]++;
                  if (exp_q[p].size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_write_p%0d actual=%h required=none", p, din_a[p]);
                  end else begin
                     chk($sformatf("egress_word_p%0d", p), 96'(din_a[p]), 96'(exp_q[p].pop_front()));
                  end
               end
            end
            if (req) begin
               if (lk_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL req_unexpected actual=1 required=0");
               end else begin
                  chk("lookup_macs", {dest_mac, src_mac}, {lk_q[0].dmac, lk_q[0].smac});
               end
            end
            if (chk_full3 && port3_full) begin
               full3_seen++;
               chk("stall_on_full3", {94'd0, rd_en, port3_wr_en}, 96'd0);
            end
         end
      end
   end

   // Ingress FIFO, FIB and egress-status models, updated just after each rising edge.
   initial begin
      lk_t         t;
      logic [71:0] junk;
      ack = 0; forward_port = 0; empty = 1; dout = 0; full_drv = 0; half_drv = 0;
      forever begin
         @(posedge sys_clk);
         #1;
         if (sys_rst) begin
            ack    = 0;
            lk_cnt = 0;
         end else begin
            if (pop_pend && in_q.size() > 0) junk = in_q.pop_front();
            if (ack_take) begin
               if (lk_q.size() > 0) t = lk_q.pop_front();
               ack          = 0;
               lk_cnt       = 0;
               forward_port = 5'($urandom);
               lk_done++;
            end else if (req_s && !ack && lk_q.size() > 0) begin
               lk_cnt++;
               if (lk_cnt >= lk_q[0].dly) begin
                  ack          = 1;
                  forward_port = lk_q[0].fp;
               end
            end
         end
         if (in_q.size() == 0 || (gap_rand && $urandom_range(0, 4) == 0)) begin
            empty = 1;
            dout  = {8'($urandom), $urandom, $urandom};
         end else begin
            empty = 0;
            dout  = in_q[0];
         end
         for (int p = 0; p < 5; p++) begin
            full_drv[p] = bp_rand && ($urandom_range(0, 7) == 0);
            half_drv[p] = bp_rand && ($urandom_range(0, 5) == 0);
         end
         if (force_half2) half_drv[2] = 1'b1;
         if (force_full3) full_drv[3] = 1'b1;
      end
   end

   initial begin
      int         base[5];
      int         n, lk0, k, nb;
      logic [47:0] dmac, smac;
      sys_rst = 1;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("reset_ctrl", {89'd0, rd_en, req, wr_v}, 96'd0);
      chk("reset_macs", {dest_mac, src_mac}, 96'd0);
      chk("reset_din", 96'(port0_din | port1_din | port2_din | port3_din | port4_din), 96'd0);
      @(posedge sys_clk);
      #1 sys_rst = 0;

      // 64-byte frame to port 1 with a 3-cycle lookup.
      dmac = 48'h00a0de1c07e8;
      smac = 48'h00a0de1c07e2;
      frm.delete();
      frm.push_back({8'hFF, dmac, smac[47:32]});
      frm.push_back({8'hFF, smac[31:0], $urandom});
      for (int i = 0; i < 6; i++) frm.push_back({8'hFF, $urandom, $urandom});
      frm.push_back({8'h00, 64'd0});
      base = wr_cnt;
      push_frame(5'b00010, 3);
      drain("drain_basic", 500);
      chk("basic_dest_mac", 96'(dest_mac), 96'h00a0de1c07e8);
      chk("basic_src_mac", 96'(src_mac), 96'h00a0de1c07e2);
      chk("basic_p1_words", 96'(wr_cnt[1] - base[1]), 96'd9);
      chk("basic_others_silent",
          96'(wr_cnt[0] + wr_cnt[2] + wr_cnt[3] + wr_cnt[4] - base[0] - base[2] - base[3] - base[4]), 96'd0);

      // Lookup selects only this port: frame dropped, next frame forwarded.
      base = wr_cnt;
      build_frame(5, 0);
      push_frame(5'b00001, 1);
      build_frame(4, 3);
      push_frame(5'b00100, 2);
      drain("drain_selfdrop", 500);
      chk("selfdrop_p2_words", 96'(wr_cnt[2] - base[2]), 96'd5);
      chk("selfdrop_p0_silent", 96'(wr_cnt[0] - base[0]), 96'd0);

      // Broadcast held off by port 2 half-full.
      base = wr_cnt;
      force_half2 = 1;
      build_frame(6, 5);
      push_frame(5'b11111, 1);
      repeat (10) @(posedge sys_clk);
      n = 0;
      for (int p = 0; p < 5; p++) n += wr_cnt[p] - base[p];
      chk("bcast_hold_on_half", 96'(n), 96'd0);
      force_half2 = 0;
      drain("drain_bcast", 500);
      chk("bcast_p0_silent", 96'(wr_cnt[0] - base[0]), 96'd0);
      chk("bcast_p4_words", 96'(wr_cnt[4] - base[4]), 96'd7);

      // Port 3 full pulsed mid-stream.
      base = wr_cnt;
      chk_full3 = 1;
      build_frame(12, 2);
      push_frame(5'b01000, 1);
      n = 0;
      while (wr_cnt[3] - base[3] < 4 && n < 500) begin
         @(posedge sys_clk);
         n++;
      end
      chk("full3_reach_stream", 96'(n < 500), 96'd1);
      force_full3 = 1;
      repeat (3) @(posedge sys_clk);
      force_full3 = 0;
      drain("drain_full3", 500);
      chk_full3 = 0;
      chk("full3_pulse_seen", 96'(full3_seen > 0), 96'd1);
      chk("full3_p3_words", 96'(wr_cnt[3] - base[3]), 96'd13);

      // Runts: word 1 last, word 0 last, then a normal frame.
      lk0 = lk_done;
      build_frame(1, 2);
      push_frame(5'b00010, 1);
      build_frame(0, 0);
      push_frame(5'b00010, 1);
      build_frame(3, 1);
      push_frame(5'b10000, 1);
      drain("drain_runt", 500);
      chk("runt_lookups", 96'(lk_done - lk0), 96'd1);

      // Randomised traffic with ingress gaps and egress backpressure.
      bp_rand  = 1;
      gap_rand = 1;
      for (int f = 0; f < 40; f++) begin
         k  = $urandom_range(0, 9);
         nb = (k == 0) ? 0 : (k == 1) ? 1 : $urandom_range(2, 10);
         build_frame(nb, $urandom_range(0, 7));
         push_frame(5'($urandom), $urandom_range(1, 4));
      end
      drain("drain_random", 30000);
      bp_rand  = 0;
      gap_rand = 0;
      repeat (4) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("final_idle", {94'd0, rd_en, req}, 96'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
